uart_word_tx: RTL and testbench

// - Transmit-side counterpart of the word-receive path.
// - Pops 32-bit words from a buffer_fifo-style read port (read_req/empty/data), breaks each word into bytes, and serializes them as 8N1 UART frames on tx.
// - Sits directly downstream of the receive FIFO; placed on the same FIFO it forms an echo/loopback path.

---
 rtl/uart_word_tx.sv | 117 +++++++++++
 tb/tb_uart_word_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: pops words from a FIFO read port and sends their bytes MSB-byte first as 8N1 frames.
// Define UART_WORD_TX_PARITY_EN to send 8E1 frames (even parity bit before the stop bit).
module uart_word_tx #(
  parameter int WORD_SIZE = 32,
  parameter int WORD_PART = 8,
  parameter int BAUD      = 115200,
  parameter int CLK_FREQ  = 200_000_000
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 fifo_empty,
  input  logic [WORD_SIZE-1:0] fifo_data,
  output logic                 read_req,
  output logic                 tx,
  output logic                 busy,
  output logic                 word_done
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int NB  = WORD_SIZE / WORD_PART;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIW = (WORD_PART > 1) ? $clog2(WORD_PART) : 1;
  localparam int BYW = (NB > 1) ? $clog2(NB) : 1;

  if (DIV < 2) begin : g_div_chk
    $error("uart_word_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (WORD_SIZE % WORD_PART != 0) begin : g_part_chk
    $error("uart_word_tx: WORD_SIZE must be a multiple of WORD_PART");
  end

`ifdef UART_WORD_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [WORD_SIZE-1:0] word;
  logic [CW-1:0]        cnt;
  logic [BIW-1:0]       bit_idx;
  logic [BYW-1:0]       byte_idx;
  logic [WORD_PART-1:0] cur;
  logic                 last_tick;

  // the byte on the wire always sits at the top of the shift word
  assign cur       = word[WORD_SIZE-1 -: WORD_PART];
  assign last_tick = cnt == CW'(DIV - 1);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      tx        <= 1'b1;
      read_req  <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
      word      <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
    end else begin
      read_req  <= 1'b0;
      word_done <= 1'b0;
      cnt       <= (state == IDLE || state == FETCH || last_tick) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (!fifo_empty) begin
          read_req <= 1'b1;
          busy     <= 1'b1;
          state    <= FETCH;
        end
        FETCH: begin
          word     <= fifo_data;
          byte_idx <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: if (last_tick) begin
          bit_idx <= '0;
          tx      <= cur[0];
          state   <= DATA;
        end
        DATA: if (last_tick) begin
          if (bit_idx == BIW'(WORD_PART - 1)) begin
`ifdef UART_WORD_TX_PARITY_EN
            tx    <= ^cur;
            state <= PARITY;
`else
            tx    <= 1'b1;
            state <= STOP;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= cur[bit_idx + 1'b1];
          end
        end
`ifdef UART_WORD_TX_PARITY_EN
        PARITY: if (last_tick) begin
          tx    <= 1'b1;
          state <= STOP;
        end
`endif
        STOP: if (last_tick) begin
          if (byte_idx == BYW'(NB - 1)) begin
            busy      <= 1'b0;
            word_done <= 1'b1;
            state     <= IDLE;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            word     <= word << WORD_PART;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: table-driven and hand-written checks of uart_word_tx with a byte scoreboard fed by a line monitor.
module tb_uart_word_tx;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int BT = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic fifo_empty = 1'b1;
  logic [31:0] fifo_data = '0;
  logic read_req, tx, busy, word_done;

  logic rstn_d = 1'b0;
  logic empty_d = 1'b1;
  logic [31:0] data_d = 32'h0100_0000;
  logic read_req_d, tx_d, busy_d, word_done_d;

  uart_word_tx #(.WORD_SIZE(32), .WORD_PART(8), .BAUD(1), .CLK_FREQ(16)) u_dut (
    .clock(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .read_req(read_req), .tx(tx), .busy(busy), .word_done(word_done)
  );

  uart_word_tx u_def (
    .clock(clk), .rstn(rstn_d), .fifo_empty(empty_d), .fifo_data(data_d),
    .read_req(read_req_d), .tx(tx_d), .busy(busy_d), .word_done(word_done_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rr_cnt = 0;
  int wd_cnt = 0;
  int viol = 0;
  logic toggle = 1'b0;
  logic mon_en = 1'b1;
  logic m_act = 1'b0;
  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  logic        obs_par[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic push_word(input logic [31:0] w, input logic [7:0] b0, b1, b2, b3);
    fifo_q.push_back(w);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
  endtask

  task automatic wait_tx_low(input string name, output int at);
    int n = 0;
    while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (tx !== 1'b0) tmo(name);
    at = cyc;
  endtask

  task automatic wait_done(input string name, output int at);
    int n = 0;
    while (word_done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (word_done !== 1'b1) tmo(name);
    at = cyc;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !busy && !m_act) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (busy || exp_q.size() != 0) tmo(name);
    repeat (3) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO model: show-ahead data, the pop lands one cycle after the read strobe was seen
  initial begin
    logic pend = 1'b0;
    logic rr_prev = 1'b0;
    logic wd_prev = 1'b0;
    logic [31:0] junk;
    forever begin
      @(negedge clk);
      if (pend && fifo_q.size() > 0) junk = fifo_q.pop_front();
      if (read_req && fifo_empty) viol++;
      if (read_req && rr_prev) viol++;
      if (read_req && word_done) viol++;
      if (word_done && wd_prev) viol++;
      if (read_req && !rr_prev) rr_cnt++;
      if (word_done) wd_cnt++;
      pend = read_req && rstn;
      rr_prev = read_req;
      wd_prev = word_done;
      fifo_empty = (toggle && busy) ? cyc[0] : (fifo_q.size() == 0);
      fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    end
  end

  // line monitor: captures each bit at its first cycle, requires it stable for the full bit time
  initial begin
    int m_c = 0;
    logic m_ok = 1'b1;
    logic [10:0] fr = '1;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rstn || !mon_en) m_act = 1'b0;
      else begin
        if (!m_act && tx === 1'b0) begin
          m_act = 1'b1;
          m_c = 0;
          m_ok = 1'b1;
        end
        if (m_act) begin
          if (m_c % BT == 0) fr[m_c / BT] = tx;
          else if (tx !== fr[m_c / BT]) m_ok = 1'b0;
          if (m_c == FB * BT - 1) begin
            m_act = 1'b0;
            chk("bit_width", {31'd0, m_ok}, 32'd1);
            chk("stop_bit", {31'd0, fr[FB-1]}, 32'd1);
            if (exp_q.size() == 0) tmo("unexpected_byte");
            else begin
              e = exp_q.pop_front();
              chk("byte", {24'd0, fr[8:1]}, {24'd0, e});
`ifdef UART_WORD_TX_PARITY_EN
              obs_par.push_back(fr[9]);
`endif
            end
          end else m_c++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int s, d, g, rr0, w;
    logic pexp[4];
    vecs[0] = '{32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[2] = '{32'h1234_5678, 8'h12, 8'h34, 8'h56, 8'h78};
    vecs[3] = '{32'h8000_0001, 8'h80, 8'h00, 8'h00, 8'h01};
    vecs[4] = '{32'h5AA5_C33C, 8'h5A, 8'hA5, 8'hC3, 8'h3C};
    pexp = '{1'b1, 1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_read_req", {31'd0, read_req}, 32'd0);
    chk("reset_word_done", {31'd0, word_done}, 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_read", rr_cnt, 0);

    rr0 = rr_cnt;
    push_word(32'hA1B2_C3D4, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    wait_tx_low("single_start", s);
    wait_done("single_done", d);
    chk("word_done_latency", d - s, FB * 4 * BT);
    wait_idle("single_idle");
    chk("single_read_pulses", rr_cnt - rr0, 1);
    chk("single_done_pulses", wd_cnt, 1);

    rr0 = rr_cnt;
    for (int i = 0; i < 5; i++) begin
      push_word(vecs[i].w, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      wait_idle("table_idle");
    end
    chk("table_read_pulses", rr_cnt - rr0, 5);
    chk("table_done_pulses", wd_cnt, 6);

    rr0 = rr_cnt;
    push_word(32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00);
    push_word(32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wait_done("b2b_first_done", d);
    g = 0;
    while (tx === 1'b1 && g < 10) begin g++; @(negedge clk); end
    chk("b2b_gap", g, 2);
    wait_idle("b2b_idle");
    chk("b2b_read_pulses", rr_cnt - rr0, 2);

    rr0 = rr_cnt;
    toggle = 1'b1;
    push_word(32'hDEAD_BEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    wait_idle("toggle_idle");
    repeat (20) @(negedge clk);
    toggle = 1'b0;
    chk("toggle_read_pulses", rr_cnt - rr0, 1);

`ifdef UART_WORD_TX_PARITY_EN
    obs_par.delete();
    push_word(32'h0700_0001, 8'h07, 8'h00, 8'h00, 8'h01);
    wait_idle("parity_idle");
    chk("parity_count", obs_par.size(), 4);
    for (int i = 0; i < 4 && i < obs_par.size(); i++)
      chk("parity_bit", {31'd0, obs_par[i]}, {31'd0, pexp[i]});
`endif

    push_word(32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_tx_low("reset_start", s);
    while (cyc < s + 2 * FB * BT + 3 * BT + 8) @(negedge clk);
    chk("pre_reset_tx", {31'd0, tx}, 32'd0);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_reset_tx", {31'd0, tx}, 32'd1);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    chk("mid_reset_read_req", {31'd0, read_req}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    rr0 = rr_cnt;
    repeat (100) @(negedge clk);
    chk("post_reset_no_read", rr_cnt - rr0, 0);
    chk("post_reset_tx", {31'd0, tx}, 32'd1);

    rstn_d = 1'b1;
    @(negedge clk);
    empty_d = 1'b0;
    g = 0;
    while (read_req_d !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    if (read_req_d !== 1'b1) tmo("default_read");
    empty_d = 1'b1;
    g = 0;
    while (tx_d !== 1'b0 && g < 20) begin @(negedge clk); g++; end
    if (tx_d !== 1'b0) tmo("default_start");
    w = 0;
    while (tx_d === 1'b0 && w < 3000) begin w++; @(negedge clk); end
    chk("default_start_width", w, 1736);
    rstn_d = 1'b0;

    chk("invariants", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
